// File: rtl/jtcop_obj_dma_pkg.sv
// Shared widths and FSM encoding for the MXC-06 object-table DMA.
package jtcop_obj_dma_pkg;
  localparam int OBJ_AW = 10;
  localparam int OBJ_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_FLUSH = 2'd2
  } dma_state_t;
endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port 0 writes, port 1 reads with a registered output.
module jtframe_dual_ram
  import jtcop_obj_dma_pkg::*;
#(
  parameter int AW = OBJ_AW + 1,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] q1_o
);
  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we0_i) mem[addr0_i] <= data0_i;
    q1_o <= mem[addr1_i];
  end
endmodule

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA: copies CPU object RAM into the back bank of a
// double-buffered table and swaps banks at the start of vertical blank.
module jtcop_obj_dma
  import jtcop_obj_dma_pkg::*;
#(
  parameter int AW = OBJ_AW,
  parameter int DW = OBJ_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dma_trig,
  input  logic          cpu_cs,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  input  logic [AW-1:0] tbl_addr,
  output logic [DW-1:0] tbl_dout,
  output logic          dma_busy,
  output logic          bank
);
  localparam logic [AW-1:0] LAST = '1;
  localparam logic [AW-1:0] ONE  = AW'(1);

  dma_state_t    state_q;
  logic [AW-1:0] rd_cnt_q, wr_cnt_q;
  logic          rd_valid_q, done_q;
  logic          busy_q, bank_q, lvbl_q;
  logic          we, lvbl_fall;

  // A retrigger drops the write still in flight from the old pass.
  assign we        = rd_valid_q & (state_q != ST_IDLE) & ~dma_trig;
  assign lvbl_fall = lvbl_q & ~LVBL;

  assign ram_addr = rd_cnt_q;
  assign dma_busy = busy_q;
  assign bank     = bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      bank_q     <= 1'b0;
      lvbl_q     <= 1'b0;
    end else begin
      lvbl_q <= LVBL;
      if (lvbl_fall && done_q) begin
        bank_q <= ~bank_q;
        done_q <= 1'b0;
      end
      if (we) wr_cnt_q <= wr_cnt_q + ONE;
      if (dma_trig) begin
        state_q    <= ST_COPY;
        rd_cnt_q   <= '0;
        wr_cnt_q   <= '0;
        rd_valid_q <= 1'b0;
        done_q     <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: rd_valid_q <= 1'b0;
          ST_COPY: begin
            if (cpu_cs) begin
              rd_valid_q <= 1'b0;
            end else begin
              rd_valid_q <= 1'b1;
              if (rd_cnt_q == LAST) state_q <= ST_FLUSH;
              else rd_cnt_q <= rd_cnt_q + ONE;
            end
          end
          ST_FLUSH: begin
            rd_valid_q <= 1'b0;
            if (!rd_valid_q) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  jtframe_dual_ram #(
    .AW (AW + 1),
    .DW (DW)
  ) u_tbl (
    .clk     (clk),
    .addr0_i ({~bank_q, wr_cnt_q}),
    .data0_i (ram_dout),
    .we0_i   (we),
    .addr1_i ({bank_q, tbl_addr}),
    .q1_o    (tbl_dout)
  );
endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Directed bench for jtcop_obj_dma with a behavioural object RAM.
module tb_jtcop_obj_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        LVBL = 1'b1;
  logic        dma_trig = 1'b0;
  logic        cpu_cs = 1'b0;
  logic [9:0]  ram_addr;
  logic [15:0] ram_dout;
  logic [9:0]  tbl_addr = '0;
  logic [15:0] tbl_dout;
  logic        dma_busy;
  logic        bank;

  int total = 0;
  int bad = 0;
  int n;

  logic [15:0] objram [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= objram[ram_addr];

  jtcop_obj_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .LVBL     (LVBL),
    .dma_trig (dma_trig),
    .cpu_cs   (cpu_cs),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .tbl_addr (tbl_addr),
    .tbl_dout (tbl_dout),
    .dma_busy (dma_busy),
    .bank     (bank)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] key);
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] a;
      a = 16'(k);
      objram[k] = a ^ key;
    end
  endtask

  task automatic chk_table(input string tag, input logic [15:0] key);
    int errs;
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      logic [15:0] a;
      a = 16'(k);
      tbl_addr = 10'(k);
      tick();
      if (tbl_dout !== (a ^ key)) errs++;
    end
    chk(tag, 32'(errs), 32'd0);
  endtask

  task automatic vbl();
    LVBL = 1'b0;
    tick();
    tick();
    LVBL = 1'b1;
    tick();
  endtask

  task automatic run_copy(input bit stall, input int vbl_at,
                          output int cnt);
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    cnt = 0;
    while (dma_busy && cnt < 4000) begin
      cpu_cs = stall && (cnt % 3 == 2);
      if (cnt == vbl_at) LVBL = 1'b0;
      if (cnt == vbl_at + 3) LVBL = 1'b1;
      tick();
      cnt++;
    end
    cpu_cs = 1'b0;
    LVBL = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (dma_busy && c < 4000) begin
      tick();
      c++;
    end
    chk(tag, 32'(dma_busy), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_bank", 32'(bank), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // plain copy then swap
    fill(16'h5A5A);
    run_copy(1'b0, -1, n);
    chk("busy_len", 32'(n), 32'd1026);
    chk("no_swap_yet", 32'(bank), 32'd0);
    vbl();
    chk("swap1_bank", 32'(bank), 32'd1);
    chk_table("tbl_5a5a", 16'h5A5A);

    // stalled copy with a vblank arriving while busy
    fill(16'h1234);
    run_copy(1'b1, 600, n);
    chk("stall_len", 32'(n), 32'd1537);
    chk("busy_vbl_bank", 32'(bank), 32'd1);
    chk_table("old_tbl_kept", 16'h5A5A);
    vbl();
    chk("swap2_bank", 32'(bank), 32'd0);
    chk_table("tbl_stall", 16'h1234);

    // retrigger at word 500 with new RAM contents
    fill(16'h3C3C);
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    fill(16'hFFFF);
    run_copy(1'b0, -1, n);
    chk("retrig_len", 32'(n), 32'd1026);
    vbl();
    chk("retrig_swap", 32'(bank), 32'd1);
    vbl();
    chk("one_swap", 32'(bank), 32'd1);
    chk_table("tbl_retrig", 16'hFFFF);

    // trigger and vblank fall in the same cycle with done set
    fill(16'h0F0F);
    run_copy(1'b0, -1, n);
    chk("pre_len", 32'(n), 32'd1026);
    fill(16'h7777);
    LVBL = 1'b0;
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    LVBL = 1'b1;
    chk("same_cyc_bank", 32'(bank), 32'd0);
    chk("same_cyc_busy", 32'(dma_busy), 32'd1);
    chk_table("front_during", 16'h0F0F);
    wait_idle("same_cyc_idle");
    vbl();
    chk("same_cyc_swap", 32'(bank), 32'd1);
    chk_table("tbl_7777", 16'h7777);

    // reset in the middle of a copy
    fill(16'h1111);
    dma_trig = 1'b1;
    tick();
    dma_trig = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(dma_busy), 32'd0);
    chk("midrst_bank", 32'(bank), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_copy(1'b0, -1, n);
    chk("post_rst_len", 32'(n), 32'd1026);
    vbl();
    chk("post_rst_bank", 32'(bank), 32'd1);
    chk_table("tbl_post_rst", 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtcop_obj_dma.md
# jtcop_obj_dma

Object-table DMA controller for the MXC-06 sprite path. It copies the 1024-word CPU object RAM into a double-buffered table whenever the CPU writes the DMA register. It swaps the front/back banks at the start of vertical blank, so the object draw engine always parses a complete, stable frame list. It sits between the CPU object RAM (a shared port it arbitrates with the CPU) and the draw engine's `tbl_addr`/`tbl_dout` port.

## Interface
Parameters:
- `AW`, 10, table address width (1024 words)
- `DW`, 16, word width

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `LVBL`  in  1  vertical blank, active low
- `dma_trig`  in  1  one-cycle pulse on CPU write to DMA register
- `cpu_cs`  in  1  CPU owns the object RAM port this cycle; DMA must not use it
- `ram_addr`  out  AW  object RAM read address (DMA side)
- `ram_dout`  in  DW  object RAM data, valid one cycle after `ram_addr`
- `tbl_addr`  in  AW  draw-engine table address
- `tbl_dout`  out  DW  draw-engine table data, registered, 1-cycle latency
- `dma_busy`  out  1  copy in progress
- `bank`  out  1  current front bank (read by draw engine)

## Operation
- States: IDLE, COPY, FLUSH.
- IDLE -> COPY on `dma_trig`. `rd_cnt`=0, `wr_cnt`=0, `done`=0, `dma_busy`=1.
- COPY, read side:
  - Each cycle with `cpu_cs`=0: `ram_addr`=`rd_cnt`, `rd_valid`<=1, `rd_cnt`++.
  - With `cpu_cs`=1: `rd_cnt` holds, `rd_valid`<=0.
- COPY, write side: when `rd_valid`=1, write `ram_dout` to back bank (`~bank`) at `wr_cnt`, then `wr_cnt`++.
- COPY -> FLUSH when the read of address 1023 is issued.
- FLUSH: performs the final pending write, then goes to IDLE with `done`<=1 and `dma_busy`<=0.
- `dma_trig` during COPY/FLUSH restarts the copy at address 0. Any pending write for the old pass is discarded; `done` stays 0.
- Bank swap happens on the LVBL falling edge (registered edge detect):
  - If `done`=1: `bank`<=~bank, `done`<=0.
  - If a copy is in progress or `done`=0: no swap. The front bank stays intact.
- A `dma_trig` and an LVBL edge in the same cycle: the swap, if `done`=1, is evaluated first; the new copy then targets the new back bank.
- Table storage: 2×1024×DW. Draw-engine read address = {`bank`, `tbl_addr`}. DMA write address = {~`bank`, `wr_cnt`}.
- Counters are AW bits. `rd_cnt` never wraps inside a pass; the terminal count is detected at 1023.

## Timing
- Reset values: `dma_busy`=0, `bank`=0, `ram_addr`=0. `tbl_dout` is the RAM registered output (0 after reset if the RAM is initialised to 0). Internally `done`=0, state IDLE.
- Uncontended copy: trigger at cycle T, first `ram_addr` valid at T+1, last write at T+1025, `dma_busy` falls at T+1026.
- Each `cpu_cs` cycle during COPY adds exactly one cycle.
- `tbl_dout` reflects `tbl_addr` one cycle later. A swap takes effect on reads issued the cycle after the edge.
- Reset mid-copy: state returns to IDLE and `bank`=0. Partially written data is ignored until the next complete copy.

## Structure
- Shared package/header: `OBJ_AW`=10, `OBJ_DW`=16, and the state encoding (IDLE=0, COPY=1, FLUSH=2).
- One sub-module: `jtframe_dual_ram` (AW+1 address, DW data). DMA writes on port 0; the draw engine reads on port 1.
- The control FSM, counters and edge detect stay in `jtcop_obj_dma`.

## Test plan
- Fill object RAM with word = addr ^ 16'h5A5A; pulse `dma_trig` with `cpu_cs`=0 -> `dma_busy` high for exactly 1026 cycles. After the next LVBL fall, `tbl_addr`=k returns k ^ 16'h5A5A for all k, and `bank`=1.
- Same copy with `cpu_cs` high every third cycle -> copy stretches by the stall count, with no missing or duplicated words (full table compare).
- LVBL falls while `dma_busy`=1 -> `bank` unchanged and old table still read. Swap occurs on the following LVBL fall after completion.
- Retrigger at word 500 with RAM contents changed to ~addr -> final table equals ~addr everywhere, one swap only.
- `dma_trig` and LVBL fall in the same cycle with `done`=1 -> `bank` toggles; the new copy writes the now-back bank, and front-bank reads are unaffected throughout.
- Assert `rst_n`=0 mid-copy -> `dma_busy`=0 and `bank`=0 immediately. A subsequent full copy and swap works normally.
